// File: rtl/debug_frame_tx.sv
// Framed snapshot transmitter: header byte, BUS_WIDTH/8 payload bytes MSB-first, optional checksum.
// Define DEBUG_FRAME_CHECKSUM_EN to append the mod-256 sum of header and payload as a final byte.
module debug_frame_tx #(
    parameter int         BUS_WIDTH   = 1736,
    parameter logic [7:0] HEADER      = 8'hA5,
    parameter int         ACK_TIMEOUT = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 send,
    input  logic [BUS_WIDTH-1:0] snapshot,
    input  logic                 tx_busy,
    output logic                 wr_uart,
    output logic [7:0]           w_data,
    output logic                 busy,
    output logic                 data_sent,
    output logic                 timeout_err
);
    localparam int N     = BUS_WIDTH / 8;
    localparam int IDX_W = $clog2(N + 2);
    localparam int TMR_W = $clog2(ACK_TIMEOUT);
`ifdef DEBUG_FRAME_CHECKSUM_EN
    localparam int LAST  = N + 1;
`else
    localparam int LAST  = N;
`endif
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LAST);
    // Abort on the cycle whose increment would bring the timer to ACK_TIMEOUT-1.
    localparam logic [TMR_W-1:0] TMR_LIM  = TMR_W'(ACK_TIMEOUT - 2);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ISSUE     = 3'd1;
    localparam logic [2:0] S_WAIT_ACK  = 3'd2;
    localparam logic [2:0] S_WAIT_IDLE = 3'd3;
    localparam logic [2:0] S_DONE      = 3'd4;

    logic [2:0]           r_state;
    logic [BUS_WIDTH-1:0] r_shadow;
    logic [IDX_W-1:0]     r_idx;
    logic [TMR_W-1:0]     r_timer;
    logic                 r_wr_uart;
    logic [7:0]           r_w_data;
    logic                 r_busy;
    logic                 r_data_sent;
    logic                 r_timeout_err;
    logic [7:0]           w_byte;
    logic                 w_is_payload;
    logic                 w_accept;
    logic                 w_issue;

    assign w_accept = (r_state == S_IDLE) && send;
    assign w_issue  = (r_state == S_ISSUE) && !tx_busy;

`ifdef DEBUG_FRAME_CHECKSUM_EN
    logic [7:0] r_cks;
    assign w_is_payload = (r_idx != '0) && (r_idx != LAST_IDX);
    always_comb begin
        w_byte = r_shadow[BUS_WIDTH-1 -: 8];
        if (r_idx == '0)
            w_byte = HEADER;
        else if (r_idx == LAST_IDX)
            w_byte = r_cks;
    end
    always_ff @(posedge clock) begin
        if (reset)
            r_cks <= 8'h00;
        else if (w_accept)
            r_cks <= 8'h00;
        else if (w_issue)
            r_cks <= r_cks + w_byte;
    end
`else
    assign w_is_payload = (r_idx != '0);
    always_comb begin
        w_byte = r_shadow[BUS_WIDTH-1 -: 8];
        if (r_idx == '0)
            w_byte = HEADER;
    end
`endif

    // Shadow is pure datapath: every consumer is gated by state, so it needs no reset.
    always_ff @(posedge clock) begin
        if (w_accept)
            r_shadow <= snapshot;
        else if (w_issue && w_is_payload)
            r_shadow <= r_shadow << 8;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_idx         <= '0;
            r_timer       <= '0;
            r_wr_uart     <= 1'b0;
            r_w_data      <= 8'h00;
            r_busy        <= 1'b0;
            r_data_sent   <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_wr_uart   <= 1'b0;
            r_data_sent <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (send) begin
                        r_idx         <= '0;
                        r_busy        <= 1'b1;
                        r_timeout_err <= 1'b0;
                        r_state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!tx_busy) begin
                        r_wr_uart <= 1'b1;
                        r_w_data  <= w_byte;
                        r_timer   <= '0;
                        r_state   <= S_WAIT_ACK;
                    end
                end
                S_WAIT_ACK: begin
                    if (tx_busy) begin
                        r_state <= S_WAIT_IDLE;
                    end else if (r_timer == TMR_LIM) begin
                        r_timeout_err <= 1'b1;
                        r_busy        <= 1'b0;
                        r_state       <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                S_WAIT_IDLE: begin
                    if (!tx_busy) begin
                        if (r_idx == LAST_IDX) begin
                            r_data_sent <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_idx   <= r_idx + IDX_W'(1);
                            r_state <= S_ISSUE;
                        end
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign wr_uart     = r_wr_uart;
    assign w_data      = r_w_data;
    assign busy        = r_busy;
    assign data_sent   = r_data_sent;
    assign timeout_err = r_timeout_err;
endmodule

// File: tb/tb_debug_frame_tx.sv
// Bench for debug_frame_tx: random snapshots against a byte-list frame model and a simple UART model.
module tb_debug_frame_tx;
    localparam int         BW  = 16;
    localparam int         N   = BW / 8;
    localparam logic [7:0] HDR = 8'hA5;
    localparam int         TO  = 16;
`ifdef DEBUG_FRAME_CHECKSUM_EN
    localparam int FL = N + 2;
`else
    localparam int FL = N + 1;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          send  = 1'b0;
    logic [BW-1:0] snapshot = '0;
    logic          tx_busy;
    logic          wr_uart;
    logic [7:0]    w_data;
    logic          busy;
    logic          data_sent;
    logic          timeout_err;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    debug_frame_tx #(.BUS_WIDTH(BW), .HEADER(HDR), .ACK_TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset), .send(send), .snapshot(snapshot), .tx_busy(tx_busy),
        .wr_uart(wr_uart), .w_data(w_data), .busy(busy), .data_sent(data_sent),
        .timeout_err(timeout_err)
    );

    // UART model: busy for hold_len cycles starting the cycle after a strobe.
    int   busy_cnt    = 0;
    int   hold_len    = 10;
    bit   uart_ack_en = 1'b1;
    logic forced_busy = 1'b0;
    always @(posedge clock) begin
        if (wr_uart && uart_ack_en) busy_cnt <= hold_len;
        else if (busy_cnt > 0)      busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt > 0) || forced_busy;

    logic [7:0] seen[$];
    int         ds_cnt = 0;
    always @(negedge clock) begin
        if (wr_uart)   seen.push_back(w_data);
        if (data_sent) ds_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_frame(input logic [BW-1:0] snap);
        @(negedge clock);
        seen.delete();
        ds_cnt   = 0;
        snapshot = snap;
        send     = 1'b1;
        @(negedge clock);
        send     = 1'b0;
        snapshot = BW'($urandom);
        check("busy_on_accept", 32'(busy), 32'd1);
        check("err_cleared", 32'(timeout_err), 32'd0);
    endtask

    task automatic finish_frame(input logic [BW-1:0] snap, input bit exp_to, input int release_at,
                                input bit rnd_send, input bit chain);
        logic [7:0] exp_q[$];
        logic [7:0] sum;
        logic       p1 = 1'b0, p2 = 1'b0;
        int         cycles = 0, wr_first = -1;
        exp_q.push_back(HDR);
        for (int i = 0; i < N; i++) exp_q.push_back(snap[BW-1-8*i -: 8]);
`ifdef DEBUG_FRAME_CHECKSUM_EN
        sum = 8'h00;
        foreach (exp_q[i]) sum = sum + exp_q[i];
        exp_q.push_back(sum);
`endif
        forever begin
            @(negedge clock);
            if (wr_uart && wr_first < 0) wr_first = cycles;
            if (data_sent || timeout_err || cycles >= 2000) break;
            if (cycles == release_at) forced_busy = 1'b0;
            send = rnd_send && ($urandom_range(0, 3) == 0);
            p2 = p1;
            p1 = tx_busy;
            cycles++;
        end
        send = chain;
        check("within_bound", 32'(cycles < 2000), 32'd1);
        check("timeout_flag", 32'(timeout_err), 32'(exp_to));
        if (release_at >= 0) check("first_wr_after_release", 32'(wr_first), 32'(release_at + 1));
        if (exp_to) begin
            check("timeout_latency", 32'(cycles - wr_first), 32'(TO - 1));
            check("busy_after_timeout", 32'(busy), 32'd0);
            repeat (5) @(negedge clock);
            check("timeout_strobes", 32'(seen.size()), 32'd1);
            check("timeout_hdr", 32'(seen.size() > 0 ? seen[0] : 8'h00), 32'(HDR));
            check("timeout_no_sent", 32'(ds_cnt), 32'd0);
        end else begin
            check("sent_after_fall", 32'({p2, p1}), 32'b10);
            check("busy_in_done", 32'(busy), 32'd1);
            @(negedge clock);
            check("sent_one_cycle", 32'(data_sent), 32'd0);
            check("busy_after_done", 32'(busy), 32'd0);
            check("sent_count", 32'(ds_cnt), 32'd1);
            check("frame_len", 32'(seen.size()), 32'(FL));
            for (int i = 0; i < FL && i < seen.size(); i++)
                check($sformatf("byte%0d", i), 32'(seen[i]), 32'(exp_q[i]));
            $display("frame snap=%h bytes=%p", snap, seen);
        end
    endtask

    initial begin
        logic [BW-1:0] a, b;
        int            cnt0;
        repeat (3) @(negedge clock);
        check("rst_wr_uart", 32'(wr_uart), 32'd0);
        check("rst_w_data", 32'(w_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_data_sent", 32'(data_sent), 32'd0);
        check("rst_timeout", 32'(timeout_err), 32'd0);
        reset = 1'b0;

        // Directed frame; snapshot scrambled after accept must not leak in.
        hold_len = 10;
        start_frame(16'h1234);
        snapshot = 16'hFFFF;
        finish_frame(16'h1234, 1'b0, -1, 1'b1, 1'b0);

        for (int k = 0; k < 8; k++) begin
            hold_len = $urandom_range(1, 12);
            a = BW'($urandom);
            start_frame(a);
            finish_frame(a, 1'b0, -1, 1'b1, 1'b0);
        end

        // Back-to-back with send held through DONE.
        hold_len = 10;
        a = BW'($urandom);
        b = BW'($urandom);
        start_frame(a);
        snapshot = b;
        finish_frame(a, 1'b0, -1, 1'b0, 1'b1);
        seen.delete();
        ds_cnt = 0;
        @(negedge clock);
        check("chain_busy", 32'(busy), 32'd1);
        send     = 1'b0;
        snapshot = BW'($urandom);
        finish_frame(b, 1'b0, -1, 1'b1, 1'b0);

        // Ack never arrives, then the next send clears the error.
        uart_ack_en = 1'b0;
        a = BW'($urandom);
        start_frame(a);
        finish_frame(a, 1'b1, -1, 1'b0, 1'b0);
        uart_ack_en = 1'b1;
        start_frame(16'h1234);
        finish_frame(16'h1234, 1'b0, -1, 1'b0, 1'b0);

        // Reset while the second byte is pending.
        start_frame(16'h1234);
        for (int i = 0; i < 200 && seen.size() < 1; i++) @(negedge clock);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("mid_rst_wr_uart", 32'(wr_uart), 32'd0);
        check("mid_rst_w_data", 32'(w_data), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_data_sent", 32'(data_sent), 32'd0);
        check("mid_rst_timeout", 32'(timeout_err), 32'd0);
        reset  = 1'b0;
        cnt0   = seen.size();
        ds_cnt = 0;
        repeat (30) @(negedge clock);
        check("no_strobe_after_rst", 32'(seen.size()), 32'(cnt0));
        check("no_sent_after_rst", 32'(ds_cnt), 32'd0);
        start_frame(16'h1234);
        finish_frame(16'h1234, 1'b0, -1, 1'b0, 1'b0);

        // UART busy before the send: first strobe waits for it to drop.
        forced_busy = 1'b1;
        repeat (20) @(negedge clock);
        a = BW'($urandom);
        start_frame(a);
        finish_frame(a, 1'b0, 4, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end
endmodule
